// File: rtl/vector_out_memory.sv
// Output-image memory for the vector datapath: lane-masked vector stores, a registered
// vector load port and a valid/ready dump sequencer that drains the whole array in order.
module vector_out_memory #(
  parameter int WIDTH = 24,
  parameter int DEPTH = 10000,
  parameter int LANES = 8,
  parameter int BASE  = 24
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        we,
  input  logic [LANES-1:0]            lane_en,
  input  logic [WIDTH-1:0]            address,
  input  logic [LANES-1:0][WIDTH-1:0] wd,
  input  logic                        re,
  output logic [LANES-1:0][WIDTH-1:0] rd,
  output logic                        rd_valid,
  output logic                        oob,
  input  logic                        dump_start,
  output logic                        dump_valid,
  input  logic                        dump_ready,
  output logic [WIDTH-1:0]            dump_data,
  output logic [WIDTH-1:0]            dump_addr,
  output logic                        dump_busy,
  output logic                        dump_done
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [WIDTH:0]  BASE_X   = (WIDTH+1)'(BASE);
  localparam logic [WIDTH:0]  DEPTH_X  = (WIDTH+1)'(DEPTH);
  localparam logic [AW-1:0]   LAST_IDX = AW'(DEPTH-1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_SHOW  = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  logic [WIDTH-1:0] mem_r [DEPTH];

  logic [WIDTH:0]                rel_s;
  logic                          below_base_s;
  logic [LANES-1:0][WIDTH:0]     lane_sum_s;
  logic [LANES-1:0][AW-1:0]      lane_idx_s;
  logic [LANES-1:0]              in_range_s;
  logic [LANES-1:0]              wr_en_s;
  logic                          load_s;

  logic [LANES-1:0][WIDTH-1:0]   rd_r;
  logic                          rd_valid_r;
  logic                          oob_r;

  logic [1:0]                    state_r;
  logic [1:0]                    state_nxt_s;
  logic [AW-1:0]                 idx_r;
  logic [AW-1:0]                 idx_nxt_s;
  logic                          dump_valid_r;
  logic [WIDTH-1:0]              dump_data_r;
  logic [WIDTH-1:0]              dump_addr_r;
  logic                          dump_busy_r;
  logic                          dump_done_r;

  // Lane address decode; the extra top bit keeps address - BASE from wrapping unnoticed.
  always_comb begin
    below_base_s = ({1'b0, address} < BASE_X);
    rel_s        = {1'b0, address} - BASE_X;
    lane_sum_s   = '0;
    lane_idx_s   = '0;
    in_range_s   = '0;
    for (int i = 0; i < LANES; i++) begin
      // Highest lane maps to the lowest word.
      lane_sum_s[i] = rel_s + (WIDTH+1)'(LANES-1-i);
      lane_idx_s[i] = lane_sum_s[i][AW-1:0];
      in_range_s[i] = !below_base_s && (lane_sum_s[i] < DEPTH_X);
    end
  end

  assign wr_en_s = {LANES{we}} & lane_en & in_range_s;
  assign load_s  = re && !dump_busy_r;

  // Storage array; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < LANES; i++) begin
      if (wr_en_s[i]) begin
        mem_r[lane_idx_s[i]] <= wd[i];
      end
    end
  end

  // Vector load port and out-of-range flag (read-first against a same-cycle store).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_r       <= '0;
      rd_valid_r <= 1'b0;
      oob_r      <= 1'b0;
    end else begin
      rd_valid_r <= load_s;
      oob_r      <= (we && |(lane_en & ~in_range_s)) || (load_s && |(~in_range_s));
      if (load_s) begin
        for (int i = 0; i < LANES; i++) begin
          rd_r[i] <= in_range_s[i] ? mem_r[lane_idx_s[i]] : '0;
        end
      end
    end
  end

  // Dump sequencer next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    idx_nxt_s   = idx_r;
    case (state_r)
      ST_IDLE: begin
        if (dump_start) begin
          state_nxt_s = ST_FETCH;
          idx_nxt_s   = '0;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_FETCH: state_nxt_s = ST_SHOW;
      ST_SHOW: begin
        if (dump_ready) begin
          if (idx_r == LAST_IDX) begin
            state_nxt_s = ST_DONE;
          end else begin
            idx_nxt_s   = idx_r + AW'(1);
            state_nxt_s = ST_FETCH;
          end
        end else begin
          state_nxt_s = ST_SHOW;
        end
      end
      ST_DONE: state_nxt_s = ST_IDLE;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Dump sequencer state and registered handshake outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      idx_r        <= '0;
      dump_valid_r <= 1'b0;
      dump_data_r  <= '0;
      dump_addr_r  <= '0;
      dump_busy_r  <= 1'b0;
      dump_done_r  <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      idx_r        <= idx_nxt_s;
      dump_valid_r <= (state_nxt_s == ST_SHOW);
      dump_busy_r  <= (state_nxt_s != ST_IDLE);
      dump_done_r  <= (state_nxt_s == ST_DONE);
      // Word is latched once per fetch, so later stores to it cannot disturb the shown value.
      if (state_r == ST_FETCH) begin
        dump_data_r <= mem_r[idx_r];
        dump_addr_r <= {{(WIDTH-AW){1'b0}}, idx_r};
      end
    end
  end

  assign rd         = rd_r;
  assign rd_valid   = rd_valid_r;
  assign oob        = oob_r;
  assign dump_valid = dump_valid_r;
  assign dump_data  = dump_data_r;
  assign dump_addr  = dump_addr_r;
  assign dump_busy  = dump_busy_r;
  assign dump_done  = dump_done_r;

endmodule
